mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Parametrised successor to the single-word pipeline memory stage.
- Sits between EX/MEM and MEM/WB and drives a synchronous data RAM.
- Adds byte/halfword/word loads and stores with sign or zero extension, byte-lane write enables and a configurable RAM read latency.
- Adds a ready/valid stall handshake and misaligned/illegal access detection.

Parameters:
ADDR_W, 14, word-address width of the data RAM (RAM depth 2^ADDR_W words)
RD_LAT, 1, RAM read latency in cycles; legal range 1..4
XLEN, 32, data width; only 32 is supported, other values are illegal

Ports:
clk  input  1  system clock; all state updates on posedge
rst  input  1  asynchronous active-low reset
valid  input  1  access request qualifier from EX/MEM
mem_read  input  1  load request
mem_write  input  1  store request
funct3  input  3  RV32I width/sign code
addr  input  32  byte address (ALU result)
wdata  input  32  store data (rs2)
ready  output  1  1 = unit can accept a request; 0 = pipeline must stall
rdata  output  32  extended load result
rdata_valid  output  1  one-cycle pulse when rdata is new
access_err  output  1  one-cycle pulse on misaligned or illegal access
ram_en  output  1  RAM enable
ram_we  output  4  RAM byte-lane write enables
ram_addr  output  ADDR_W  RAM word address = addr[ADDR_W+1:2]
ram_wdata  output  32  lane-replicated store data
ram_rdata  input  32  RAM read data, valid RD_LAT cycles after ram_en with ram_we=0

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; rdata=0, rdata_valid=0, access_err=0, latency counter=0.
- Reset wins over any in-flight load: the load is discarded and no rdata_valid is produced.
- States: IDLE and WAIT. ready=1 only in IDLE.
- Request accepted when valid=1 and ready=1. Requests with valid=0 or with neither mem_read nor mem_write are ignored (no RAM activity).
- Legal funct3 for loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal funct3 for stores: 000 SB, 001 SH, 010 SW.
- Alignment: H requires addr[0]=0; W requires addr[1:0]=00.
- Error cases: illegal funct3, misalignment, or mem_read=1 and mem_write=1 together.
  - Next posedge: access_err=1 for one cycle.
  - No RAM enable or write; state stays IDLE; rdata is held.
- Store, accepted in IDLE and legal: same cycle, combinationally, ram_en=1, ram_we=lane mask, ram_wdata=replicated data.
  - SB: ram_we = 0001 << addr[1:0], ram_wdata = {4{wdata[7:0]}}.
  - SH: ram_we = 0011 << addr[1:0], ram_wdata = {2{wdata[15:0]}}.
  - SW: ram_we = 1111, ram_wdata = wdata.
  - Store completes in one cycle, does not stall and produces no rdata_valid.
- Load, accepted in IDLE and legal:
  - Same cycle: ram_en=1, ram_we=0000.
  - Registers funct3 and addr[1:0], loads counter=RD_LAT-1, then goes to WAIT (ready=0).
  - In WAIT: counter decrements each cycle. The edge on which the counter is 0 captures ram_rdata, applies extension, sets rdata and pulses rdata_valid, and returns to IDLE.
  - Total latency from accept edge to rdata_valid high: RD_LAT+1 edges. With RD_LAT=1: request in cycle 0, ready=0 in cycle 1, rdata_valid=1 in cycle 2.
- Extension: the byte or halfword is selected by the registered addr[1:0].
  - LB/LH: sign-extend from bit 7/15.
  - LBU/LHU: zero-extend.
  - LW: passthrough.
- Inputs arriving in WAIT are ignored; upstream holds them because ready=0.
- rdata holds its last value until the next load completes.
- ram_addr is driven from addr in IDLE and from the registered word address in WAIT.

Optional Feature:
MEM_PERF_CNT_EN
- Defined: adds outputs load_cnt[31:0] and store_cnt[31:0].
  - load_cnt increments on each rdata_valid pulse; store_cnt increments on each accepted legal store.
  - Error accesses are counted in neither; both counters wrap at 2^32.
  - Both reset to 0 on rst=0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- SW addr=0x10 wdata=0xDEADBEEF, then LW addr=0x10 (RD_LAT=1) -> first cycle ram_we=1111, ram_addr=4; rdata=0xDEADBEEF with rdata_valid 2 edges after the load is accepted; ready=0 for exactly 1 cycle.
- SB addr=0x13 wdata=0x80, then LB and LBU at 0x13 -> ram_we=1000; LB rdata=0xFFFFFF80, LBU rdata=0x00000080.
- SH addr=0x22 wdata=0x00008001, then LH and LHU at 0x22 -> ram_we=1100; LH rdata=0xFFFF8001, LHU rdata=0x00008001.
- LW addr=0x11; SH addr=0x21; load with funct3=011 -> each pulses access_err for one cycle, ram_en=0, rdata unchanged, ready stays 1.
- RD_LAT=3, LW issued, rst pulsed low during WAIT -> outputs 0 immediately, state IDLE, no rdata_valid after rst release.
- MEM_PERF_CNT_EN defined: 3 stores, 2 loads, 1 misaligned load -> store_cnt=3, load_cnt=2.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Pipeline memory stage between EX/MEM and MEM/WB. It drives a synchronous
//   data RAM and provides byte/halfword/word loads and stores with sign or zero
//   extension. A load stalls the pipeline through ready=0 until the RAM data
//   returns. Misaligned or illegal accesses give a one-cycle access_err pulse
//   and cause no RAM activity.
//
//   Parameters
//     ADDR_W : RAM word-address width (RAM depth is 2^ADDR_W words), 1..30
//     RD_LAT : RAM read latency in cycles, 1..4
//     XLEN   : data width, must be 32
//
//   Optional build macro
//     MEM_PERF_CNT_EN : adds the free-running load_cnt/store_cnt outputs
//
//   Ports
//     clk, rst          clock; asynchronous active-low reset
//     valid             request qualifier from EX/MEM
//     mem_read          load request
//     mem_write         store request
//     funct3            RV32I width/sign code
//     addr, wdata       byte address and store data
//     ready             1 = a request can be accepted, 0 = pipeline stalls
//     rdata             extended load result, held until the next load completes
//     rdata_valid       one-cycle pulse when rdata is new
//     access_err        one-cycle pulse after a misaligned or illegal access
//     ram_en, ram_we    RAM enable and byte-lane write enables
//     ram_addr          RAM word address
//     ram_wdata         lane-replicated store data
//     ram_rdata         RAM read data, valid RD_LAT cycles after a read enable
//     load_cnt          completed loads (MEM_PERF_CNT_EN only)
//     store_cnt         accepted stores (MEM_PERF_CNT_EN only)
//
//   state  | meaning
//   S_IDLE | ready, accepts a new request
//   S_WAIT | load in flight, counting down the RAM read latency
module mem_access_unit #(
  parameter int ADDR_W = 14,
  parameter int RD_LAT = 1,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [XLEN-1:0]   wdata,
  output logic              ready,
  output logic [XLEN-1:0]   rdata,
  output logic              rdata_valid,
  output logic              access_err,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [XLEN-1:0]   ram_wdata,
  input  logic [XLEN-1:0]   ram_rdata
`ifdef MEM_PERF_CNT_EN
  ,
  output logic [31:0]       load_cnt,
  output logic [31:0]       store_cnt
`endif
);

  if (XLEN != 32 || RD_LAT < 1 || RD_LAT > 4 || ADDR_W < 1 || ADDR_W > 30) begin : g_param_check
    $error("mem_access_unit: unsupported parameter set");
  end

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            state, state_nxt;
  logic [1:0]        cnt;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [ADDR_W-1:0] addr_q;

  logic req, load_f3_ok, store_f3_ok, misalign, err, ld_go, st_go, ld_done;

  // Only part of the byte address reaches the RAM.
  logic unused_addr;
  assign unused_addr = ^addr;

  assign ready = (state == S_IDLE);
  assign req   = valid && ready && (mem_read || mem_write);

  assign load_f3_ok  = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                       (funct3 == 3'b100) || (funct3 == 3'b101);
  assign store_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);

  // funct3[1:0] is the access size for every legal code.
  assign misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                    ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

  assign err   = req && ((mem_read && mem_write) ||
                         (mem_read && !load_f3_ok) ||
                         (mem_write && !store_f3_ok) ||
                         misalign);
  assign ld_go = req && mem_read && !err;
  assign st_go = req && mem_write && !err;

  assign ld_done = (state == S_WAIT) && (cnt == 2'd0);

  function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3,
                                                  input logic [1:0] off,
                                                  input logic [XLEN-1:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [XLEN-1:0] r;
    case (off)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = off[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'd0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'd0, h};
      default: r = d;
    endcase
    return r;
  endfunction

  always_comb begin
    state_nxt = state;
    ram_en    = 1'b0;
    ram_we    = 4'b0000;
    ram_wdata = '0;
    ram_addr  = (state == S_WAIT) ? addr_q : addr[ADDR_W+1:2];
    case (state)
      S_IDLE: begin
        if (ld_go) begin
          ram_en    = 1'b1;
          state_nxt = S_WAIT;
        end else if (st_go) begin
          ram_en = 1'b1;
          case (funct3[1:0])
            2'b00: begin
              ram_we    = 4'b0001 << addr[1:0];
              ram_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
              ram_we    = 4'b0011 << addr[1:0];
              ram_wdata = {2{wdata[15:0]}};
            end
            default: begin
              ram_we    = 4'b1111;
              ram_wdata = wdata;
            end
          endcase
        end
      end
      S_WAIT: begin
        if (cnt == 2'd0) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= 2'd0;
      f3_q        <= 3'd0;
      off_q       <= 2'd0;
      addr_q      <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      access_err  <= 1'b0;
    end else begin
      state       <= state_nxt;
      access_err  <= err;
      rdata_valid <= ld_done;
      if (ld_go) begin
        f3_q   <= funct3;
        off_q  <= addr[1:0];
        addr_q <= addr[ADDR_W+1:2];
        cnt    <= 2'(RD_LAT - 1);
      end else if ((state == S_WAIT) && (cnt != 2'd0)) begin
        cnt <= cnt - 2'd1;
      end
      if (ld_done) rdata <= load_extend(f3_q, off_q, ram_rdata);
    end
  end

`ifdef MEM_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_cnt  <= 32'd0;
      store_cnt <= 32'd0;
    end else begin
      if (ld_done) load_cnt  <= load_cnt + 32'd1;
      if (st_go)   store_cnt <= store_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  localparam int ADDR_W = 14;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;

  logic              ready, rdata_valid, access_err, ram_en;
  logic [31:0]       rdata, ram_wdata, ram_rdata;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;

  logic              ready3, rdata_valid3, access_err3, ram_en3;
  logic [31:0]       rdata3, ram_wdata3;
  logic [31:0]       ram_rdata3 = 32'h1234_5678;
  logic [3:0]        ram_we3;
  logic [ADDR_W-1:0] ram_addr3;

`ifdef MEM_PERF_CNT_EN
  logic [31:0] load_cnt, store_cnt, load_cnt3, store_cnt3;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(ADDR_W), .RD_LAT(1), .XLEN(32)) u1 (
    .clk(clk), .rst(rst), .valid(valid), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata), .ready(ready), .rdata(rdata),
    .rdata_valid(rdata_valid), .access_err(access_err), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef MEM_PERF_CNT_EN
    , .load_cnt(load_cnt), .store_cnt(store_cnt)
`endif
  );

  mem_access_unit #(.ADDR_W(ADDR_W), .RD_LAT(3), .XLEN(32)) u3 (
    .clk(clk), .rst(rst), .valid(valid), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata), .ready(ready3), .rdata(rdata3),
    .rdata_valid(rdata_valid3), .access_err(access_err3), .ram_en(ram_en3), .ram_we(ram_we3),
    .ram_addr(ram_addr3), .ram_wdata(ram_wdata3), .ram_rdata(ram_rdata3)
`ifdef MEM_PERF_CNT_EN
    , .load_cnt(load_cnt3), .store_cnt(store_cnt3)
`endif
  );

  // Synchronous RAM model, one-cycle read latency, byte-lane writes.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (ram_en) begin
      for (int i = 0; i < 4; i++)
        if (ram_we[i]) mem[ram_addr[7:0]][8*i +: 8] <= ram_wdata[8*i +: 8];
      if (ram_we == 4'b0000) ram_rdata <= mem[ram_addr[7:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] we, input logic [31:0] wd);
    @(negedge clk);
    valid = 1'b1; mem_write = 1'b1; mem_read = 1'b0; funct3 = f3; addr = a; wdata = d;
    #1;
    chk("st_en", 32'(ram_en), 32'd1);
    chk("st_we", 32'(ram_we), 32'(we));
    chk("st_wdata", ram_wdata, wd);
    chk("st_addr", 32'(ram_addr), 32'(a[15:2]));
    chk("st_ready", 32'(ready), 32'd1);
    @(posedge clk); #1;
    valid = 1'b0; mem_write = 1'b0;
    chk("st_no_rv", 32'(rdata_valid), 32'd0);
    chk("st_no_stall", 32'(ready), 32'd1);
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = f3; addr = a;
    #1;
    chk("ld_en", 32'(ram_en), 32'd1);
    chk("ld_we", 32'(ram_we), 32'd0);
    chk("ld_addr", 32'(ram_addr), 32'(a[15:2]));
    @(posedge clk); #1;
    valid = 1'b0; mem_read = 1'b0; addr = 32'h0000_FFFC;
    #1;
    chk("ld_stall", 32'(ready), 32'd0);
    chk("ld_rv_early", 32'(rdata_valid), 32'd0);
    chk("ld_wait_addr", 32'(ram_addr), 32'(a[15:2]));
    @(posedge clk); #1;
    chk("ld_rv", 32'(rdata_valid), 32'd1);
    chk("ld_rdata", rdata, exp);
    chk("ld_ready", 32'(ready), 32'd1);
    @(posedge clk); #1;
    chk("ld_rv_pulse", 32'(rdata_valid), 32'd0);
    chk("ld_hold", rdata, exp);
  endtask

  task automatic do_err(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] prev);
    @(negedge clk);
    valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = 32'hA5A5_A5A5;
    #1;
    chk("er_en", 32'(ram_en), 32'd0);
    chk("er_we", 32'(ram_we), 32'd0);
    chk("er_ready", 32'(ready), 32'd1);
    @(posedge clk); #1;
    valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    chk("er_pulse", 32'(access_err), 32'd1);
    chk("er_idle", 32'(ready), 32'd1);
    chk("er_hold", rdata, prev);
    chk("er_no_rv", 32'(rdata_valid), 32'd0);
    @(posedge clk); #1;
    chk("er_pulse_end", 32'(access_err), 32'd0);
  endtask

  initial begin
    logic seen;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rv", 32'(rdata_valid), 32'd0);
    chk("rst_err", 32'(access_err), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
`ifdef MEM_PERF_CNT_EN
    chk("rst_load_cnt", load_cnt, 32'd0);
    chk("rst_store_cnt", store_cnt, 32'd0);
`endif
    @(negedge clk); rst = 1'b1;

    do_store(3'b010, 32'h10, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    do_load (3'b010, 32'h10, 32'hDEAD_BEEF);
    do_store(3'b000, 32'h13, 32'h0000_0080, 4'b1000, 32'h8080_8080);
    do_load (3'b000, 32'h13, 32'hFFFF_FF80);
    do_load (3'b100, 32'h13, 32'h0000_0080);
    do_load (3'b000, 32'h10, 32'hFFFF_FFEF);
    do_load (3'b100, 32'h11, 32'h0000_00BE);
    do_store(3'b001, 32'h22, 32'h0000_8001, 4'b1100, 32'h8001_8001);
    do_load (3'b001, 32'h22, 32'hFFFF_8001);
    do_load (3'b101, 32'h22, 32'h0000_8001);

    do_err(1'b1, 1'b0, 3'b010, 32'h11, 32'h0000_8001);
    do_err(1'b0, 1'b1, 3'b001, 32'h21, 32'h0000_8001);
    do_err(1'b1, 1'b0, 3'b011, 32'h10, 32'h0000_8001);
    do_err(1'b1, 1'b1, 3'b010, 32'h10, 32'h0000_8001);
    do_err(1'b0, 1'b1, 3'b100, 32'h10, 32'h0000_8001);

    // Requests that must be ignored entirely.
    @(negedge clk);
    valid = 1'b0; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h10;
    #1 chk("ign_novalid_en", 32'(ram_en), 32'd0);
    @(posedge clk); #1;
    chk("ign_novalid_ready", 32'(ready), 32'd1);
    @(negedge clk);
    valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    #1 chk("ign_noop_en", 32'(ram_en), 32'd0);
    @(posedge clk); #1;
    valid = 1'b0;
    chk("ign_noop_ready", 32'(ready), 32'd1);
    chk("ign_noop_err", 32'(access_err), 32'd0);

`ifdef MEM_PERF_CNT_EN
    chk("store_cnt", store_cnt, 32'd3);
    chk("load_cnt", load_cnt, 32'd7);
`endif

    // RD_LAT=3 instance: full load latency, then reset during a pending load.
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h10;
    @(posedge clk); #1;
    valid = 1'b0; mem_read = 1'b0;
    chk("l3_stall", 32'(ready3), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("l3_still_stall", 32'(ready3), 32'd0);
    chk("l3_rv_early", 32'(rdata_valid3), 32'd0);
    @(posedge clk); #1;
    chk("l3_rv", 32'(rdata_valid3), 32'd1);
    chk("l3_rdata", rdata3, 32'h1234_5678);

    @(negedge clk);
    valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h10;
    @(posedge clk); #1;
    valid = 1'b0; mem_read = 1'b0;
    @(posedge clk); #1;
    chk("l3_wait2", 32'(ready3), 32'd0);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("r3_rdata", rdata3, 32'd0);
    chk("r3_ready", 32'(ready3), 32'd1);
    chk("r3_rv", 32'(rdata_valid3), 32'd0);
    chk("r3_err", 32'(access_err3), 32'd0);
    #2 rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (rdata_valid3) seen = 1'b1;
    end
    chk("r3_no_rv_after", 32'(seen), 32'd0);
    chk("r3_idle_after", 32'(ready3), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
